// File: rtl/uart_rx_core.sv
// 8N1 UART receiver, 16x oversampled with 3-sample majority vote; optional even parity via UART_RX_PARITY_EN.
// Latency: rx_int/frame_err one cycle after the mid-stop-bit vote (edge detect + 154*OVS_DIV + 1, or 170*OVS_DIV + 1 with parity).
// Backpressure: none; rx_data holds until the next good frame, so the consumer must take it within one frame time.
module uart_rx_core #(
    parameter int unsigned OVS_DIV = 27
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rs232_rx,
    output logic [7:0] rx_data,
    output logic       rx_int,
    output logic       frame_err,
    output logic       parity_err,
    output logic       rx_busy
);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    localparam logic [15:0] TICK_MAX = 16'(OVS_DIV - 1);

    state_t      state_q, state_d;
    logic        sync1_q, sync2_q, sync3_q;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  s_q, s_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [1:0]  smp_q, smp_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_int_q, rx_int_d;
    logic        frame_err_q, frame_err_d;
    logic        rx_busy_q, rx_busy_d;
    logic        start_edge, tick, vote;

    assign start_edge = sync3_q & ~sync2_q;
    assign tick       = (cnt_q == TICK_MAX);
    // smp_q holds the s=7 and s=8 samples; the live line supplies the s=9 one
    assign vote       = (smp_q[0] & smp_q[1]) | (smp_q[0] & sync2_q) | (smp_q[1] & sync2_q);

`ifdef UART_RX_PARITY_EN
    logic par_q, par_d;
    logic parity_err_q, parity_err_d;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        s_d         = s_q;
        bit_d       = bit_q;
        shreg_d     = shreg_q;
        smp_d       = smp_q;
        rx_data_d   = rx_data_q;
        rx_int_d    = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d        = par_q;
        parity_err_d = 1'b0;
`endif
        if (state_q == S_IDLE) begin
            cnt_d = '0;
            s_d   = '0;
            bit_d = '0;
            if (start_edge) state_d = S_START;
        end else begin
            cnt_d = tick ? 16'd0 : cnt_q + 16'd1;
            if (tick) begin
                s_d = s_q + 4'd1;
                if (s_q == 4'd7) smp_d[0] = sync2_q;
                if (s_q == 4'd8) smp_d[1] = sync2_q;
                case (state_q)
                    S_START: begin
                        if (s_q == 4'd9 && vote) begin
                            state_d = S_IDLE;
                        end else if (s_q == 4'd15) begin
                            state_d = S_DATA;
                            bit_d   = 3'd0;
                        end
                    end
                    S_DATA: begin
                        if (s_q == 4'd9) shreg_d[bit_q] = vote;
                        if (s_q == 4'd15) begin
                            bit_d = bit_q + 3'd1;
                            if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                                state_d = S_PARITY;
`else
                                state_d = S_STOP;
`endif
                            end
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    S_PARITY: begin
                        if (s_q == 4'd9) par_d = vote;
                        if (s_q == 4'd15) state_d = S_STOP;
                    end
`endif
                    S_STOP: begin
                        // Leaving at mid-stop-bit lets a back-to-back start edge be caught
                        if (s_q == 4'd9) begin
                            state_d = S_IDLE;
                            if (vote) begin
                                rx_data_d = shreg_q;
                                rx_int_d  = 1'b1;
`ifdef UART_RX_PARITY_EN
                                parity_err_d = (^shreg_q) ^ par_q;
`endif
                            end else begin
                                frame_err_d = 1'b1;
                            end
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end
        rx_busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            sync3_q     <= 1'b1;
            cnt_q       <= '0;
            s_q         <= '0;
            bit_q       <= '0;
            shreg_q     <= '0;
            smp_q       <= '0;
            rx_data_q   <= '0;
            rx_int_q    <= 1'b0;
            frame_err_q <= 1'b0;
            rx_busy_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= rs232_rx;
            sync2_q     <= sync1_q;
            sync3_q     <= sync2_q;
            cnt_q       <= cnt_d;
            s_q         <= s_d;
            bit_q       <= bit_d;
            shreg_q     <= shreg_d;
            smp_q       <= smp_d;
            rx_data_q   <= rx_data_d;
            rx_int_q    <= rx_int_d;
            frame_err_q <= frame_err_d;
            rx_busy_q   <= rx_busy_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
        end
    end
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign rx_data   = rx_data_q;
    assign rx_int    = rx_int_q;
    assign frame_err = frame_err_q;
    assign rx_busy   = rx_busy_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core at OVS_DIV=4 (64 clk per bit).
module tb_uart_rx_core;

    localparam int BIT_CLKS = 64;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 170 * 4 + 1;
`else
    localparam int LAT = 154 * 4 + 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rs232_rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_int, frame_err, parity_err, rx_busy;

    uart_rx_core #(.OVS_DIV(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rs232_rx   (rs232_rx),
        .rx_data    (rx_data),
        .rx_int     (rx_int),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .rx_busy    (rx_busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         ferr;
        logic [7:0] data;
        bit         perr;
        int         at;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per output strobe
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && (rx_int === 1'b1 || frame_err === 1'b1)) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_strobe got rx_int=%b frame_err=%b rx_data=%h want none (cycle %0d)",
                         rx_int, frame_err, rx_data, cyc);
            end else begin
                e = sb.pop_front();
                chk("rx_int", 32'(rx_int), 32'(!e.ferr));
                chk("frame_err", 32'(frame_err), 32'(e.ferr));
                chk("rx_data", 32'(rx_data), 32'(e.data));
                chk("parity_err", 32'(parity_err), 32'(e.perr));
                chk("strobe_cycle", 32'(cyc), 32'(e.at));
                chk("busy_at_strobe", 32'(rx_busy), 32'd0);
            end
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rs232_rx = b;
        wait_clks(BIT_CLKS);
    endtask

    // Sends one frame; the expectation is pushed before the line falls
    task automatic send(input logic [7:0] d, input logic par, input logic stop,
                        input bit exp_ferr, input logic [7:0] exp_data, input bit exp_perr);
        exp_t e;
        e.ferr = exp_ferr;
        e.data = exp_data;
        e.perr = exp_perr;
        e.at   = cyc + 2 + LAT;
        sb.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par);
`else
        if (par) rs232_rx = 1'b1;
`endif
        drive_bit(stop);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rx_data"}, 32'(rx_data), 32'h00);
        chk({tag, "_rx_int"}, 32'(rx_int), 32'd0);
        chk({tag, "_frame_err"}, 32'(frame_err), 32'd0);
        chk({tag, "_parity_err"}, 32'(parity_err), 32'd0);
        chk({tag, "_rx_busy"}, 32'(rx_busy), 32'd0);
    endtask

    int fall;

    initial begin
        wait_clks(3);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        wait_clks(20);

        // Stop bit low, line stays low (break), then a clean frame
        send(8'h3C, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        wait_clks(2000);
        rs232_rx = 1'b1;
        wait_clks(BIT_CLKS);
        send(8'h7E, 1'b0, 1'b1, 1'b0, 8'h7E, 1'b0);
        wait_clks(100);

        // Back-to-back frames, no idle between them
        send(8'h55, 1'b0, 1'b1, 1'b0, 8'h55, 1'b0);
        send(8'hA3, 1'b0, 1'b1, 1'b0, 8'hA3, 1'b0);
        wait_clks(100);

        // Glitch: 20 clk low is a false start
        fall = cyc;
        rs232_rx = 1'b0;
        wait_clks(2);
        chk("glitch_busy_at_edge", 32'(rx_busy), 32'd0);
        wait_clks(1);
        chk("glitch_busy_after_edge", 32'(rx_busy), 32'd1);
        wait_clks(fall + 20 - cyc);
        rs232_rx = 1'b1;
        wait_clks(fall + 43 - cyc);
        chk("glitch_busy_cleared", 32'(rx_busy), 32'd0);
        wait_clks(700);

        // Reset in the middle of data bit 4 of 0xFF
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        rs232_rx = 1'b1;
        wait_clks(32);
        rst_n = 1'b0;
        wait_clks(1);
        chk_reset_outputs("midreset");
        wait_clks(3);
        rst_n = 1'b1;
        wait_clks(100);
        send(8'h81, 1'b0, 1'b1, 1'b0, 8'h81, 1'b0);
        wait_clks(100);

`ifdef UART_RX_PARITY_EN
        send(8'h07, 1'b1, 1'b1, 1'b0, 8'h07, 1'b0);
        send(8'h07, 1'b0, 1'b1, 1'b0, 8'h07, 1'b1);
        wait_clks(100);
`endif

        wait_clks(200);
        chk("missing_strobes", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
